pio_uart_tx: RTL
================

Name: pio_uart_tx

Overview:
- Serial transmitter directly downstream of the 8-bit Avalon PIO output port in the Nios serial-communication subsystem.
- Takes the PIO byte (tx_data) and a software-toggled start level (tx_start, a second PIO bit).
- On each rising edge of tx_start, latches the byte and shifts it out as an asynchronous UART frame on tx.
- Reports progress through busy and a one-cycle done pulse.

Parameters:
- BAUD_DIV, 434, clk cycles per bit period (50 MHz / 115200); legal range 1..65535.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  in  1  system clock, same domain as the PIO.
- reset_n  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to send, driven by PIO out_port.
- tx_start  in  1  start level; a rising edge requests one frame.
- tx  out  1  UART serial line, idle high.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk. While reset_n=0:
  - tx=1, busy=0, done=0.
  - FSM goes to IDLE; baud counter, bit counter and shift register are cleared.
  - start_q (previous tx_start) is cleared to 0.
- Edge detect:
  - start_q is registered every cycle.
  - start_edge = tx_start & ~start_q.
  - A tx_start held high through reset release triggers one frame.
- Acceptance:
  - start_edge is honoured only in IDLE.
  - On the accepting clk edge, tx_data is captured into the shift register, the parity bit is computed and the FSM enters START.
  - tx=0 and busy=1 are visible from the next cycle.
- FSM states and bit order:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: 8 bits, LSB first.
  - PARITY: present only if PARITY != 0.
  - STOP: tx=1, STOP_BITS periods.
- Bit timing:
  - Every bit lasts exactly BAUD_DIV cycles.
  - The baud counter runs 0..BAUD_DIV-1, reloads to 0 at each bit boundary and is reset to 0 on frame acceptance.
  - BAUD_DIV=1 gives one bit per clock.
- Parity:
  - Even parity bit = XOR of the 8 latched bits.
  - Odd parity bit = its inverse.
- Frame length: (1 + 8 + (PARITY != 0) + STOP_BITS) × BAUD_DIV cycles.
- Completion: on the last cycle of the final stop bit period:
  - done=1 for exactly that cycle.
  - busy drops to 0 on the following cycle, when the FSM is back in IDLE.
  - A start_edge in that IDLE cycle starts the next frame with no gap beyond the stop bits.
- Boundary conditions:
  - start_edge while busy: ignored, not queued. tx_start staying high afterwards produces no further frame until it falls and rises again.
  - tx_data changing mid-frame: no effect, because the byte is latched at acceptance.
  - Reset mid-frame: tx returns to 1 immediately (asynchronously); the frame is abandoned and done is not pulsed.
- Registered outputs: tx, busy and done are all registered, so there are no combinational paths from inputs to outputs.

Test Plan:
- Reset with BAUD_DIV=4, tx_start=0 -> tx=1, busy=0, done=0; holds indefinitely with no stimulus.
- BAUD_DIV=4, PARITY=0, STOP_BITS=1, tx_data=0x55, pulse tx_start -> tx produces 0,1,0,1,0,1,0,1,0,1 (4 cycles each); busy high for 40 cycles; a single done pulse in the last STOP cycle.
- BAUD_DIV=4, PARITY=1, STOP_BITS=2, tx_data=0xA3 -> bits 0 | 1,1,0,0,0,1,0,1 | parity 0 | 1,1; 48 cycles. With PARITY=2 the parity bit is 1.
- Mid-frame (cycle 10) apply a second tx_start edge and change tx_data to 0xFF -> transmitted bits unchanged; only one done pulse. Then a new edge in the first IDLE cycle after done -> second frame starts immediately with data 0xFF.
- Hold tx_start high for 200 cycles -> exactly one frame.
- Deassert reset_n at cycle 15 of a frame -> tx=1 at once, busy=0, no done; after release, an edge sends a full frame.
- BAUD_DIV=1, tx_data=0x01 -> 10-cycle frame 0,1,0,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/pio_uart_tx.sv
// UART transmitter fed by the 8-bit Avalon PIO output port.
// A rising edge on tx_start latches tx_data and sends one asynchronous frame:
// start bit, 8 data bits LSB first, an optional parity bit, then 1 or 2 stop bits.
// Ports:
//   clk      - system clock (PIO domain)
//   reset_n  - asynchronous active-low reset
//   tx_data  - byte to send, sampled when a frame is accepted
//   tx_start - start level; each rising edge seen in IDLE starts one frame
//   tx       - serial line, idle high (registered)
//   busy     - high while a frame is in progress (registered)
//   done     - one-cycle pulse in the last cycle of the final stop bit (registered)
module pio_uart_tx #(
  parameter int unsigned BAUD_DIV  = 434,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BAUD_W = 16;
  localparam int unsigned BIT_W  = 3;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  // Baud count one cycle before the end of a bit; only used when BAUD_DIV >= 2.
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(BAUD_DIV - 2);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(7);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              HAS_PAR   = (PARITY != 0);
  localparam logic              ODD_PAR   = (PARITY == 2);
  localparam logic              ONE_STOP  = (STOP_BITS == 1);
  localparam logic              DIV_ONE   = (BAUD_DIV == 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  state_e              state_q;
  logic [BAUD_W-1:0]   baud_q;
  logic [BIT_W-1:0]    bit_q;
  logic [7:0]          shift_q;
  logic                par_q;
  logic                start_q;

  logic start_edge_c;
  logic bit_end_c;
  logic final_stop_c;
  logic enter_final_c;
  logic last_next_c;

  // Edge detect and bit-boundary decode.
  assign start_edge_c = tx_start & ~start_q;
  assign bit_end_c    = (baud_q == BAUD_LAST);
  assign final_stop_c = (state_q == ST_STOP) && (bit_q == STOP_LAST);

  // The next bit slot is the final stop bit (matters only when every cycle is a bit).
  assign enter_final_c =
      ((state_q == ST_STOP) && (bit_q == '0) && !ONE_STOP) ||
      (ONE_STOP && ((state_q == ST_PAR) ||
                    ((state_q == ST_DATA) && (bit_q == DATA_LAST) && !HAS_PAR)));

  // done is registered, so it is raised one cycle ahead: true when the coming
  // cycle is the last cycle of the final stop bit.
  assign last_next_c = DIV_ONE ? enter_final_c
                               : (final_stop_c && (baud_q == BAUD_PRE));

  // Frame FSM with registered line, busy and done outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      start_q <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      start_q <= tx_start;
      done    <= last_next_c;
      case (state_q)
        ST_IDLE: begin
          if (start_edge_c) begin
            shift_q <= tx_data;
            par_q   <= (^tx_data) ^ ODD_PAR;
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= ST_START;
            tx      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ST_START, ST_DATA, ST_PAR, ST_STOP: begin
          if (!bit_end_c) begin
            baud_q <= BAUD_W'(baud_q + 1'b1);
          end else begin
            baud_q <= '0;
            case (state_q)
              ST_START: begin
                state_q <= ST_DATA;
                tx      <= shift_q[0];
              end
              ST_DATA: begin
                if (bit_q == DATA_LAST) begin
                  bit_q <= '0;
                  if (HAS_PAR) begin
                    state_q <= ST_PAR;
                    tx      <= par_q;
                  end else begin
                    state_q <= ST_STOP;
                    tx      <= 1'b1;
                  end
                end else begin
                  // Shift keeps the next data bit at index 1 ready for the line.
                  bit_q   <= BIT_W'(bit_q + 1'b1);
                  shift_q <= shift_q >> 1;
                  tx      <= shift_q[1];
                end
              end
              ST_PAR: begin
                state_q <= ST_STOP;
                tx      <= 1'b1;
              end
              default: begin
                if (bit_q == STOP_LAST) begin
                  bit_q   <= '0;
                  state_q <= ST_IDLE;
                  busy    <= 1'b0;
                end else begin
                  bit_q <= BIT_W'(bit_q + 1'b1);
                end
              end
            endcase
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
